// File: rtl/dh_exchange_ctrl.sv
// Diffie-Hellman exchange sequencer: drives one shared modular_exp engine twice
// (public key, then shared key) with operand muxing, stale-flag guard and watchdog.
module dh_exchange_ctrl #(
    parameter int WIDTH   = 100,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] prime,
    input  logic [WIDTH-1:0] gen,
    input  logic [WIDTH:0]   secret,
    input  logic [WIDTH-1:0] peer_pub,
    input  logic             peer_valid,
    output logic [WIDTH-1:0] pub_key,
    output logic             pub_valid,
    output logic [WIDTH-1:0] shared_key,
    output logic             shared_valid,
    output logic             busy,
    output logic [1:0]       err,
    output logic             eng_rst,
    output logic [WIDTH-1:0] eng_base,
    output logic [WIDTH:0]   eng_exp,
    output logic [WIDTH-1:0] eng_prime,
    input  logic [WIDTH-1:0] eng_result,
    input  logic             eng_dirty0,
    input  logic             eng_dirty1
);

    // state     | meaning
    // IDLE      | waiting for start
    // LOAD_PUB  | operands g/secret/p on engine, eng_rst pulse
    // RUN_PUB   | engine computing g^secret mod p
    // WAIT_PEER | public key out, waiting for peer value
    // CHECK     | range check 2 <= peer <= p-2
    // LOAD_SH   | operands peer/secret/p on engine, eng_rst pulse
    // RUN_SH    | engine computing peer^secret mod p
    // DONE      | finished (ok or error), start restarts
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_PUB, S_RUN_PUB, S_WAIT_PEER,
        S_CHECK, S_LOAD_SH, S_RUN_SH, S_DONE
    } state_t;

    localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prime_q, peer_q;
    logic [WIDTH:0]   secret_q;
    logic [15:0]      tmr;
    logic [1:0]       guard;

    logic accept, running, eng_idle, run_done, run_tmo, peer_ok;
    logic [WIDTH-1:0] prime_m2;

    always_comb begin
        accept   = start && (state == S_IDLE || state == S_DONE);
        running  = (state == S_RUN_PUB) || (state == S_RUN_SH);
        eng_idle = !eng_dirty0 && !eng_dirty1;
        run_done = running && (guard == 2'd0) && eng_idle;
        run_tmo  = running && !run_done && (tmr == 16'd0);
        prime_m2 = prime_q - WIDTH'(2);
        // prime < 4 leaves no legal peer values; also keeps prime-2 from wrapping
        peer_ok  = (prime_q >= WIDTH'(4)) && (peer_q >= WIDTH'(2)) && (peer_q <= prime_m2);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (accept) state_nxt = S_LOAD_PUB;
            S_LOAD_PUB:     state_nxt = S_RUN_PUB;
            S_RUN_PUB: begin
                if (run_done)     state_nxt = S_WAIT_PEER;
                else if (run_tmo) state_nxt = S_DONE;
            end
            S_WAIT_PEER:    if (peer_valid) state_nxt = S_CHECK;
            S_CHECK:        state_nxt = peer_ok ? S_LOAD_SH : S_DONE;
            S_LOAD_SH:      state_nxt = S_RUN_SH;
            S_RUN_SH:       if (run_done || run_tmo) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            prime_q      <= '0;
            peer_q       <= '0;
            secret_q     <= '0;
            tmr          <= '0;
            guard        <= '0;
            pub_key      <= '0;
            pub_valid    <= 1'b0;
            shared_key   <= '0;
            shared_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 2'b00;
            eng_rst      <= 1'b0;
            eng_base     <= '0;
            eng_exp      <= '0;
            eng_prime    <= '0;
        end else begin
            state   <= state_nxt;
            eng_rst <= (state_nxt == S_LOAD_PUB) || (state_nxt == S_LOAD_SH);
            busy    <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);

            if (accept) begin
                prime_q      <= prime;
                secret_q     <= secret;
                eng_base     <= gen;
                eng_exp      <= secret;
                eng_prime    <= prime;
                pub_valid    <= 1'b0;
                shared_valid <= 1'b0;
                err          <= 2'b00;
            end

            if (state == S_WAIT_PEER && peer_valid)
                peer_q <= peer_pub;

            if (state == S_CHECK) begin
                if (peer_ok) begin
                    eng_base  <= peer_q;
                    eng_exp   <= secret_q;
                    eng_prime <= prime_q;
                end else begin
                    err <= 2'b01;
                end
            end

            // guard and watchdog both tick from the first RUN cycle
            if (state == S_LOAD_PUB || state == S_LOAD_SH) begin
                guard <= 2'd2;
                tmr   <= TMR_LOAD;
            end else if (running) begin
                if (guard != 2'd0) guard <= guard - 2'd1;
                if (tmr != 16'd0)  tmr   <= tmr - 16'd1;
            end

            if (run_done) begin
                if (state == S_RUN_PUB) begin
                    pub_key   <= eng_result;
                    pub_valid <= 1'b1;
                end else begin
                    shared_key   <= eng_result;
                    shared_valid <= 1'b1;
                end
            end

            if (run_tmo)
                err <= 2'b10;
        end
    end

endmodule
